// File: rtl/adat_pkg.sv
// Shared ADAT framing constants and deframer state type.
package adat_pkg;

   typedef enum logic [1:0] {
      StHunt,
      StSync,
      StUser,
      StData
   } deframe_state_e;

   localparam int unsigned ADAT_SYNC_ZEROS  = 10;
   localparam int unsigned ADAT_CHANNELS    = 8;
   localparam int unsigned ADAT_NIBBLES     = 6;
   localparam int unsigned ADAT_SAMPLE_BITS = 24;
   localparam int unsigned I2S_SLOT_BITS    = 32;
   localparam int unsigned ADAT_PAD_BITS    = I2S_SLOT_BITS - ADAT_SAMPLE_BITS;

endpackage

// File: rtl/adat_pad_scheduler.sv
// Queues the zero-pad writes that fill slot bits 24..31 of a channel and
// arbitrates the single RAM write port between data and pad writes.
module adat_pad_scheduler
   import adat_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   input  logic       data_we_i,
   input  logic [7:0] data_off_i,
   input  logic       data_bit_i,
   input  logic       load_i,
   input  logic [2:0] load_ch_i,
   output logic       we_o,
   output logic [7:0] off_o,
   output logic       bit_o,
   output logic       idle_o
);

   logic [3:0] pad_cnt_q;
   logic [2:0] pad_ch_q;
   logic       pad_we;

   // Write-port arbitration: data always wins, pads fill idle cycles.
   always_comb begin
      pad_we = (pad_cnt_q != 4'd0) && !data_we_i && !flush_i;
      we_o   = data_we_i | pad_we;
      bit_o  = data_we_i ? data_bit_i : 1'b0;
      // pad_cnt 8..1 maps onto slot offsets 24..31
      off_o  = data_we_i ? data_off_i
                         : {pad_ch_q, 5'd24 + (5'd8 - {1'b0, pad_cnt_q})};
      idle_o = (pad_cnt_q == 4'd0);
   end

   // Pad counter: load after a channel's last data bit, count down per pad issued.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pad_cnt_q <= 4'd0;
         pad_ch_q  <= 3'd0;
      end else if (flush_i) begin
         pad_cnt_q <= 4'd0;
      end else if (load_i) begin
         pad_cnt_q <= 4'(ADAT_PAD_BITS);
         pad_ch_q  <= load_ch_i;
      end else if (pad_we) begin
         pad_cnt_q <= pad_cnt_q - 4'd1;
      end
   end

endmodule

// File: rtl/adat_frame_writer.sv
// ADAT deframer: hunts for sync, checks separators and writes each frame into
// the circular 1-bit frame RAM; commits completed frames and tracks lock.
module adat_frame_writer
   import adat_pkg::*;
#(
   parameter int unsigned CIRC_BUF_BITS  = 3,
   parameter int unsigned LOCK_FRAMES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     bit_i,
   input  logic                     bit_valid_i,
   output logic                     ram_we_o,
   output logic [CIRC_BUF_BITS+7:0] ram_write_addr_o,
   output logic                     ram_data_o,
   output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
   output logic                     resync_req_o,
   output logic [3:0]               user_bits_o
);

   localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

   deframe_state_e           state_q, state_d;
   logic [3:0]               zero_cnt_q, zero_cnt_d;
   logic [2:0]               bit_cnt_q, bit_cnt_d;
   logic [2:0]               nib_cnt_q, nib_cnt_d;
   logic [2:0]               ch_cnt_q, ch_cnt_d;
   logic [3:0]               shadow_q, shadow_d;
   logic [TimeoutW-1:0]      timeout_q;
   logic                     commit_pend_q;
   logic [CIRC_BUF_BITS-1:0] write_frame_q;
   logic [3:0]               lock_cnt_q, lock_next;
   logic                     sep_err, timeout_err, err, frame_done, commit;
   logic                     data_we, pad_load;
   logic [7:0]               data_off;
   logic                     wr_we, wr_bit, pad_idle;
   logic [7:0]               wr_off;

   // FSM state and frame position counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StHunt;
         zero_cnt_q <= 4'd0;
         bit_cnt_q  <= 3'd0;
         nib_cnt_q  <= 3'd0;
         ch_cnt_q   <= 3'd0;
         shadow_q   <= 4'd0;
      end else begin
         state_q    <= state_d;
         zero_cnt_q <= zero_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         nib_cnt_q  <= nib_cnt_d;
         ch_cnt_q   <= ch_cnt_d;
         shadow_q   <= shadow_d;
      end
   end

   // Next-state logic: sync search, separator checking and frame completion.
   always_comb begin
      state_d    = state_q;
      zero_cnt_d = zero_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      nib_cnt_d  = nib_cnt_q;
      ch_cnt_d   = ch_cnt_q;
      shadow_d   = shadow_q;
      sep_err    = 1'b0;
      frame_done = 1'b0;
      if (bit_valid_i) begin
         unique case (state_q)
            StHunt: begin
               if (bit_i) begin
                  zero_cnt_d = 4'd0;
                  if (zero_cnt_q == 4'(ADAT_SYNC_ZEROS)) begin
                     state_d   = StUser;
                     bit_cnt_d = 3'd0;
                  end
               end else if (zero_cnt_q != 4'(ADAT_SYNC_ZEROS)) begin
                  zero_cnt_d = zero_cnt_q + 4'd1;
               end
            end
            StSync: begin
               if (bit_i) begin
                  zero_cnt_d = 4'd0;
                  if (zero_cnt_q == 4'(ADAT_SYNC_ZEROS)) begin
                     state_d   = StUser;
                     bit_cnt_d = 3'd0;
                  end else begin
                     sep_err = 1'b1;
                  end
               end else if (zero_cnt_q == 4'(ADAT_SYNC_ZEROS)) begin
                  sep_err = 1'b1;
               end else begin
                  zero_cnt_d = zero_cnt_q + 4'd1;
               end
            end
            StUser: begin
               if (bit_cnt_q == 3'd4) begin
                  if (bit_i) begin
                     state_d   = StData;
                     bit_cnt_d = 3'd0;
                     nib_cnt_d = 3'd0;
                     ch_cnt_d  = 3'd0;
                  end else begin
                     sep_err = 1'b1;
                  end
               end else begin
                  // first user bit received is the nibble MSB
                  shadow_d[2'd3 - bit_cnt_q[1:0]] = bit_i;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            StData: begin
               if (bit_cnt_q == 3'd4) begin
                  bit_cnt_d = 3'd0;
                  if (!bit_i) begin
                     sep_err = 1'b1;
                  end else if (nib_cnt_q == 3'(ADAT_NIBBLES - 1)) begin
                     nib_cnt_d = 3'd0;
                     if (ch_cnt_q == 3'(ADAT_CHANNELS - 1)) begin
                        frame_done = 1'b1;
                        state_d    = StSync;
                        zero_cnt_d = 4'd0;
                     end else begin
                        ch_cnt_d = ch_cnt_q + 3'd1;
                     end
                  end else begin
                     nib_cnt_d = nib_cnt_q + 3'd1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            default: state_d = StHunt;
         endcase
      end
      err = sep_err | timeout_err;
      if (err) begin
         state_d    = StHunt;
         zero_cnt_d = 4'd0;
      end
   end

   // FSM outputs: data write request and pad queue load.
   always_comb begin
      data_we  = bit_valid_i && (state_q == StData) && (bit_cnt_q != 3'd4);
      // offset c*32 + nibble*4 + bit, i.e. sample MSB at slot offset 0
      data_off = {ch_cnt_q, nib_cnt_q, bit_cnt_q[1:0]};
      pad_load = data_we && (nib_cnt_q == 3'(ADAT_NIBBLES - 1)) && (bit_cnt_q == 3'd3);
   end

   adat_pad_scheduler u_pad_scheduler (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (err),
      .data_we_i  (data_we),
      .data_off_i (data_off),
      .data_bit_i (bit_i),
      .load_i     (pad_load),
      .load_ch_i  (ch_cnt_q),
      .we_o       (wr_we),
      .off_o      (wr_off),
      .bit_o      (wr_bit),
      .idle_o     (pad_idle)
   );

   // Loss-of-signal timer; fires once when the idle run reaches TIMEOUT_CYCLES.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timeout_q <= '0;
      end else if (bit_valid_i) begin
         timeout_q <= '0;
      end else if (timeout_q != TimeoutW'(TIMEOUT_CYCLES)) begin
         timeout_q <= timeout_q + 1'b1;
      end
   end

   // Commit waits for the last channel's pads; an error discards it.
   always_comb begin
      timeout_err = !bit_valid_i && (timeout_q == TimeoutW'(TIMEOUT_CYCLES - 1));
      commit      = commit_pend_q && pad_idle && !err;
      lock_next   = (lock_cnt_q == 4'hF) ? lock_cnt_q : lock_cnt_q + 4'd1;
   end

   // Registered RAM port, commit bookkeeping and lock tracking.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ram_we_o              <= 1'b0;
         ram_write_addr_o      <= '0;
         ram_data_o            <= 1'b0;
         last_good_frame_idx_o <= '0;
         resync_req_o          <= 1'b0;
         user_bits_o           <= 4'd0;
         write_frame_q         <= CIRC_BUF_BITS'(1);
         lock_cnt_q            <= 4'd0;
         commit_pend_q         <= 1'b0;
      end else begin
         ram_we_o         <= wr_we;
         ram_write_addr_o <= {write_frame_q, wr_off};
         ram_data_o       <= wr_bit;
         if (err) begin
            commit_pend_q <= 1'b0;
            lock_cnt_q    <= 4'd0;
            resync_req_o  <= 1'b0;
         end else if (frame_done) begin
            commit_pend_q <= 1'b1;
         end else if (commit) begin
            commit_pend_q         <= 1'b0;
            last_good_frame_idx_o <= write_frame_q;
            write_frame_q         <= write_frame_q + 1'b1;
            user_bits_o           <= shadow_q;
            lock_cnt_q            <= lock_next;
            resync_req_o          <= (32'(lock_next) >= LOCK_FRAMES);
         end
      end
   end

endmodule

// File: tb/tb_adat_frame_writer.sv
// Self-checking bench for adat_frame_writer: random frames against a frame-level model.
module tb_adat_frame_writer;

   localparam int unsigned CB    = 3;
   localparam int unsigned LOCKF = 4;
   localparam int unsigned TMO   = 1024;
   localparam int unsigned RAMSZ = 1 << (CB + 8);

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          bit_i = 1'b0;
   logic          bit_valid_i = 1'b0;
   logic          ram_we_o;
   logic [CB+7:0] ram_write_addr_o;
   logic          ram_data_o;
   logic [CB-1:0] last_good_frame_idx_o;
   logic          resync_req_o;
   logic [3:0]    user_bits_o;

   adat_frame_writer #(
      .CIRC_BUF_BITS  (CB),
      .LOCK_FRAMES    (LOCKF),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .bit_i                 (bit_i),
      .bit_valid_i           (bit_valid_i),
      .ram_we_o              (ram_we_o),
      .ram_write_addr_o      (ram_write_addr_o),
      .ram_data_o            (ram_data_o),
      .last_good_frame_idx_o (last_good_frame_idx_o),
      .resync_req_o          (resync_req_o),
      .user_bits_o           (user_bits_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;
   int gap = 4;

   // current frame content
   logic [23:0] samp [8];
   logic [3:0]  user;

   // frame-level model
   logic [CB-1:0] exp_wf, exp_lg;
   logic [3:0]    exp_user;
   int            exp_lock;
   int            frame_start_cnt;

   // RAM image and commit observer
   logic          ram [RAMSZ];
   int            wr_total = 0;
   int            wr_last = 0;
   int            commit_cnt = 0;
   int            commit_delta = 0;
   logic [CB-1:0] prev_lg = '0;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < RAMSZ; i++) ram[i] = 1'bx;
         wr_last = wr_total;
         prev_lg = '0;
      end else begin
         if (ram_we_o) begin
            ram[ram_write_addr_o] = ram_data_o;
            wr_total++;
         end
         if (last_good_frame_idx_o !== prev_lg) begin
            commit_delta = wr_total - wr_last;
            wr_last      = wr_total;
            prev_lg      = last_good_frame_idx_o;
            commit_cnt++;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic tail_bit(input int pos);
      int p, c, n, b;
      if (pos < 4) return user[3-pos];
      if (pos == 4) return 1'b1;
      p = pos - 5;
      c = p / 30;
      n = (p % 30) / 5;
      b = p % 5;
      if (b == 4) return 1'b1;
      return samp[c][23-(n*4+b)];
   endfunction

   function automatic logic slot_bit(input int off);
      int c, k;
      c = off / 32;
      k = off % 32;
      if (k >= 24) return 1'b0;
      return samp[c][23-k];
   endfunction

   task automatic new_frame(input bit fixed);
      for (int c = 0; c < 8; c++)
         samp[c] = fixed ? 24'hA00000 + 24'(c) : 24'($urandom);
      user = 4'($urandom);
   endtask

   task automatic do_reset();
      bit_valid_i = 1'b0;
      bit_i       = 1'b0;
      rst_ni      = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      exp_wf   = CB'(1);
      exp_lg   = '0;
      exp_user = 4'd0;
      exp_lock = 0;
   endtask

   task automatic pulse_bit(input logic b);
      @(posedge clk_i);
      #1;
      bit_i       = b;
      bit_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      bit_valid_i = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      pulse_bit(b);
      repeat (gap - 2) @(posedge clk_i);
   endtask

   task automatic send_tail(input int from, input int upto, input int bad_idx);
      logic b;
      for (int i = from; i <= upto; i++) begin
         b = tail_bit(i);
         if (i == bad_idx) b = ~b;
         send_bit(b);
      end
   endtask

   // nz sync zeros, the sync '1', then tail bits 0..ntail-1
   task automatic send_frame(input int nz, input int bad_idx, input int ntail);
      frame_start_cnt = commit_cnt;
      for (int i = 0; i < nz; i++) send_bit(1'b0);
      send_bit(1'b1);
      send_tail(0, ntail - 1, bad_idx);
   endtask

   task automatic wait_commit(input string name);
      bit seen;
      int errs;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk_i);
         #1;
         if (commit_cnt != frame_start_cnt) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s commit: none within 400 cycles, required one", name);
      end else begin
         exp_lg = exp_wf;
         exp_wf = exp_wf + 1'b1;
         if (exp_lock < 15) exp_lock++;
         exp_user = user;
         total++;
         if (last_good_frame_idx_o !== exp_lg) begin
            bad++;
            $display("FAIL %s last_good: got %0d required %0d", name, last_good_frame_idx_o,
                     exp_lg);
         end
         total++;
         if (user_bits_o !== exp_user) begin
            bad++;
            $display("FAIL %s user_bits: got %h required %h", name, user_bits_o, exp_user);
         end
         total++;
         if (resync_req_o !== (exp_lock >= int'(LOCKF))) begin
            bad++;
            $display("FAIL %s resync: got %b required %b", name, resync_req_o,
                     exp_lock >= int'(LOCKF));
         end
         total++;
         if (commit_delta != 256) begin
            bad++;
            $display("FAIL %s writes per frame: got %0d required 256", name, commit_delta);
         end
         errs = 0;
         for (int off = 0; off < 256; off++)
            if (ram[int'(exp_lg) * 256 + off] !== slot_bit(off)) errs++;
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL %s ram slot %0d: %0d wrong bits, required 0", name, exp_lg, errs);
         end
      end
   endtask

   task automatic expect_no_commit(input string name, input int cycles);
      repeat (cycles) @(negedge clk_i);
      #1;
      total++;
      if (commit_cnt != frame_start_cnt || last_good_frame_idx_o !== exp_lg) begin
         bad++;
         $display("FAIL %s no-commit: got last_good %0d, required %0d with no commit", name,
                  last_good_frame_idx_o, exp_lg);
      end
      total++;
      if (resync_req_o !== (exp_lock >= int'(LOCKF))) begin
         bad++;
         $display("FAIL %s resync: got %b required %b", name, resync_req_o,
                  exp_lock >= int'(LOCKF));
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk_i);
      total++;
      if ({ram_we_o, ram_write_addr_o, ram_data_o, last_good_frame_idx_o, resync_req_o,
           user_bits_o} !== '0) begin
         bad++;
         $display("FAIL reset outputs: got we=%b addr=%h d=%b lg=%0d rs=%b ub=%h required all 0",
                  ram_we_o, ram_write_addr_o, ram_data_o, last_good_frame_idx_o, resync_req_o,
                  user_bits_o);
      end
   endtask

   task automatic test_clean_frames();
      do_reset();
      gap = 4;
      for (int f = 0; f < 3; f++) begin
         new_frame(1'b1);
         send_frame(10, -1, 245);
         wait_commit("clean");
      end
   endtask

   task automatic test_lock_and_sep_error();
      do_reset();
      gap = 4;
      for (int f = 0; f < 5; f++) begin
         new_frame(1'b0);
         send_frame(10, -1, 245);
         wait_commit("lock");
      end
      new_frame(1'b0);
      send_frame(10, -1, 9);
      @(negedge clk_i);
      total++;
      if (resync_req_o !== 1'b1) begin
         bad++;
         $display("FAIL sep pre-error resync: got %b required 1", resync_req_o);
      end
      pulse_bit(1'b0);
      exp_lock = 0;
      total++;
      if (resync_req_o !== 1'b0) begin
         bad++;
         $display("FAIL sep error resync drop: got %b required 0", resync_req_o);
      end
      expect_no_commit("sep error", 100);
   endtask

   task automatic test_back_to_back();
      do_reset();
      gap = 2;
      for (int f = 0; f < 2; f++) begin
         new_frame(1'b0);
         send_frame(10, -1, 245);
         wait_commit("fast");
      end
   endtask

   task automatic test_sync_errors();
      do_reset();
      gap = 3;
      new_frame(1'b0);
      send_frame(10, -1, 245);
      wait_commit("sync first");
      new_frame(1'b0);
      send_frame(9, -1, 245);
      exp_lock = 0;
      expect_no_commit("sync 9 zeros", 60);
      new_frame(1'b0);
      send_frame(12, -1, 245);
      wait_commit("hunt 12 zeros");
      new_frame(1'b0);
      send_frame(11, -1, 245);
      exp_lock = 0;
      expect_no_commit("sync 11 zeros", 60);
      new_frame(1'b0);
      send_frame(10, -1, 245);
      wait_commit("relock");
   endtask

   task automatic test_wrap_and_timeout();
      do_reset();
      for (int f = 0; f < 10; f++) begin
         gap = int'($urandom_range(2, 5));
         new_frame(1'b0);
         send_frame(10, -1, 245);
         wait_commit("wrap");
      end
      frame_start_cnt = commit_cnt;
      expect_no_commit("idle below timeout", int'(TMO) - 200);
      exp_lock = 0;
      expect_no_commit("timeout", 260);
   endtask

   task automatic test_async_reset();
      int base;
      do_reset();
      gap = 4;
      new_frame(1'b0);
      send_frame(10, -1, 245);
      wait_commit("pre-reset");
      new_frame(1'b0);
      send_frame(10, -1, 5 + 3 * 30 + 12);
      @(posedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      total++;
      if ({ram_we_o, ram_write_addr_o, ram_data_o, last_good_frame_idx_o, resync_req_o,
           user_bits_o} !== '0) begin
         bad++;
         $display("FAIL async reset outputs: got we=%b addr=%h lg=%0d rs=%b ub=%h required 0",
                  ram_we_o, ram_write_addr_o, last_good_frame_idx_o, resync_req_o, user_bits_o);
      end
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      exp_wf   = CB'(1);
      exp_lg   = '0;
      exp_lock = 0;
      @(negedge clk_i);
      base = wr_total;
      frame_start_cnt = commit_cnt;
      send_tail(5 + 3 * 30 + 12, 244, -1);
      expect_no_commit("after reset", 40);
      total++;
      if (wr_total != base) begin
         bad++;
         $display("FAIL after reset writes: got %0d required 0", wr_total - base);
      end
      new_frame(1'b0);
      send_frame(10, -1, 245);
      wait_commit("fresh sync");
   endtask

   initial begin
      test_reset();
      test_clean_frames();
      test_lock_and_sep_error();
      test_back_to_back();
      test_sync_errors();
      test_wrap_and_timeout();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
